// File: rtl/countdown_timer_n.sv
// countdown_timer_n: N-digit BCD countdown timer with prescaler, run/pause/expired FSM,
// timed beep and registered seven-segment outputs. Optional blink in EXPIRED: COUNTDOWN_BLINK_EN.
module countdown_timer_n #(
  parameter int unsigned           TICK_DIV   = 50_000_000,
  parameter int unsigned           DIGITS     = 2,
  parameter logic [4*DIGITS-1:0]   START_VAL  = (4*DIGITS)'(8'h60),
  parameter int unsigned           BEEP_TICKS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  tick,
  output logic                  beep,
  output logic                  done
);

  localparam int CW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int ND = int'(DIGITS);
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSE   = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  // Ripple-borrow decrement: a zero digit becomes 9 and passes the borrow upward.
  function automatic logic [CW-1:0] dec_bcd(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] enc_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [SW-1:0] enc_bcd(input logic [CW-1:0] v);
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[7*i +: 7] = enc_digit(v[4*i +: 4]);
    end
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] reload_q, reload_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          beep_q, beep_d;
  logic          done_q, done_d;
  logic [SW-1:0] seg_q, seg_d;
  logic          tick_w;
  logic          last_tick;

  assign tick_w    = ((state_q == S_RUN) || (state_q == S_EXPIRED)) && (presc_q == PRESC_MAX);
  assign last_tick = tick_w && (count_q == CW'(1));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    presc_d    = presc_q;
    beep_cnt_d = beep_cnt_q;
    beep_d     = beep_q;
    done_d     = done_q;

    if (load) begin
      count_d    = clamp_bcd(load_val);
      reload_d   = clamp_bcd(load_val);
      presc_d    = '0;
      beep_d     = 1'b0;
      beep_cnt_d = '0;
      done_d     = 1'b0;
      state_d    = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (count_q != '0)) begin
            presc_d = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          presc_d = tick_w ? '0 : presc_q + PW'(1);
          // Reaching zero expires even when a pause request lands on the same edge.
          if (last_tick) begin
            count_d    = '0;
            done_d     = 1'b1;
            beep_d     = 1'b1;
            beep_cnt_d = '0;
            state_d    = S_EXPIRED;
          end else begin
            if (tick_w) begin
              count_d = dec_bcd(count_q);
            end
            if (start) begin
              state_d = S_PAUSE;
            end
          end
        end
        S_PAUSE: begin
          if (start) begin
            state_d = S_RUN;
          end
        end
        default: begin
          if (start && (reload_q != '0)) begin
            count_d    = reload_q;
            presc_d    = '0;
            beep_d     = 1'b0;
            beep_cnt_d = '0;
            done_d     = 1'b0;
            state_d    = S_RUN;
          end else begin
            presc_d = tick_w ? '0 : presc_q + PW'(1);
            if (tick_w && beep_q) begin
              if (beep_cnt_q == BEEP_LAST) begin
                beep_d = 1'b0;
              end else begin
                beep_cnt_d = beep_cnt_q + BW'(1);
              end
            end
          end
        end
      endcase
    end
  end

`ifdef COUNTDOWN_BLINK_EN
  logic blink_q, blink_d;

  // Blank phase toggles on every tick while EXPIRED and is forced off on exit.
  always_comb begin
    blink_d = 1'b0;
    if ((state_q == S_EXPIRED) && (state_d == S_EXPIRED)) begin
      blink_d = tick_w ? ~blink_q : blink_q;
    end
    seg_d = ((state_q == S_EXPIRED) && blink_q) ? '0 : enc_bcd(count_q);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  always_comb begin
    seg_d = enc_bcd(count_q);
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= clamp_bcd(START_VAL);
      reload_q   <= clamp_bcd(START_VAL);
      presc_q    <= '0;
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
      done_q     <= 1'b0;
      seg_q      <= enc_bcd(clamp_bcd(START_VAL));
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      presc_q    <= presc_d;
      beep_cnt_q <= beep_cnt_d;
      beep_q     <= beep_d;
      done_q     <= done_d;
      seg_q      <= seg_d;
    end
  end

  assign count = count_q;
  assign seg   = seg_q;
  assign tick  = tick_w;
  assign beep  = beep_q;
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer_n.sv
// Testbench for countdown_timer_n: directed steps plus random traffic against a decimal reference model.
module tb_countdown_timer_n;

  localparam int         TICK_DIV   = 4;
  localparam int         DIGITS     = 2;
  localparam int         BEEP_TICKS = 3;
  localparam logic [7:0] START_VAL  = 8'h03;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        load  = 1'b0;
  logic [7:0]  load_val = 8'h00;
  logic [7:0]  count;
  logic [13:0] seg;
  logic        tick;
  logic        beep;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Reference model: count held as a plain decimal integer.
  int          m_st = M_IDLE;
  int          m_val = 3;
  int          m_reload = 3;
  int          m_phase = 0;
  int          m_exp_ticks = 0;
  bit          m_beep = 1'b0;
  bit          m_done = 1'b0;
  bit          m_blank = 1'b0;
  logic [13:0] m_seg = 14'h0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  countdown_timer_n #(
    .TICK_DIV  (TICK_DIV),
    .DIGITS    (DIGITS),
    .START_VAL (START_VAL),
    .BEEP_TICKS(BEEP_TICKS)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .seg     (seg),
    .tick    (tick),
    .beep    (beep),
    .done    (done)
  );

  always #5 clock = ~clock;

  function automatic logic [13:0] seg_of(input int v);
    return {seg_tab[v / 10], seg_tab[v % 10]};
  endfunction

  function automatic logic [7:0] bcd_of(input int v);
    logic [3:0] h;
    logic [3:0] l;
    h = 4'(v / 10);
    l = 4'(v % 10);
    return {h, l};
  endfunction

  function automatic int value_of_load(input logic [7:0] lv);
    int h;
    int l;
    h = int'(lv[7:4]);
    l = int'(lv[3:0]);
    if (h > 9) h = 9;
    if (l > 9) l = 9;
    return h * 10 + l;
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit l, input logic [7:0] lv);
    bit          tick_pre;
    logic [13:0] seg_next;
    tick_pre = ((m_st == M_RUN) || (m_st == M_EXP)) && (m_phase == TICK_DIV - 1);
    seg_next = ((m_st == M_EXP) && m_blank) ? 14'h0 : seg_of(m_val);
    if (!r) begin
      m_st = M_IDLE; m_val = 3; m_reload = 3; m_phase = 0; m_exp_ticks = 0;
      m_beep = 1'b0; m_done = 1'b0; m_blank = 1'b0; m_seg = seg_of(3);
    end else begin
      m_seg = seg_next;
      if (l) begin
        m_val = value_of_load(lv); m_reload = m_val; m_phase = 0;
        m_beep = 1'b0; m_done = 1'b0; m_st = M_IDLE;
      end else if (m_st == M_IDLE) begin
        if (s && m_val != 0) begin
          m_st = M_RUN; m_phase = 0;
        end
      end else if (m_st == M_RUN) begin
        m_phase = tick_pre ? 0 : m_phase + 1;
        if (tick_pre) m_val = m_val - 1;
        if (m_val == 0) begin
          m_st = M_EXP; m_done = 1'b1; m_beep = 1'b1; m_exp_ticks = 0;
        end else if (s) begin
          m_st = M_PAUSE;
        end
      end else if (m_st == M_PAUSE) begin
        if (s) m_st = M_RUN;
      end else begin
        if (s && m_reload != 0) begin
          m_val = m_reload; m_phase = 0; m_beep = 1'b0; m_done = 1'b0; m_st = M_RUN;
        end else begin
          m_phase = tick_pre ? 0 : m_phase + 1;
          if (tick_pre) begin
            m_exp_ticks++;
            if (m_exp_ticks >= BEEP_TICKS) m_beep = 1'b0;
`ifdef COUNTDOWN_BLINK_EN
            m_blank = ~m_blank;
`endif
          end
        end
      end
      if (m_st != M_EXP) m_blank = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit exp_tick;
    exp_tick = ((m_st == M_RUN) || (m_st == M_EXP)) && (m_phase == TICK_DIV - 1);
    chk("count", {8'h0, count}, {8'h0, bcd_of(m_val)});
    chk("seg",   {2'b0, seg},   {2'b0, m_seg});
    chk("tick",  {15'h0, tick}, {15'h0, exp_tick});
    chk("beep",  {15'h0, beep}, {15'h0, m_beep});
    chk("done",  {15'h0, done}, {15'h0, m_done});
  endtask

  task automatic step(input bit r, input bit s, input bit l, input logic [7:0] lv);
    reset = r; start = s; load = l; load_val = lv;
    @(posedge clock);
    model_edge(r, s, l, lv);
    @(negedge clock);
    check_outputs();
  endtask

  initial begin
    bit          rr;
    bit          rs;
    bit          rl;
    logic [7:0]  rv;

    // reset state
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_count", {8'h0, count}, 16'h0003);
    chk("rst_seg", {2'b0, seg}, {2'b0, 7'h3F, 7'h4F});

    // countdown from 03 through expiry and beep timeout
    step(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (30) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("exp_done", {15'h0, done}, 16'h0001);
    chk("exp_beep_off", {15'h0, beep}, 16'h0000);

    // borrow 10 -> 09
    step(1'b1, 1'b0, 1'b1, 8'h10);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (6) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("borrow_count", {8'h0, count}, 16'h0009);
    chk("borrow_seg", {2'b0, seg}, {2'b0, 7'h3F, 7'h6F});

    // pause and resume
    step(1'b1, 1'b0, 1'b1, 8'h05);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (5) step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (20) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("pause_count", {8'h0, count}, 16'h0004);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (12) step(1'b1, 1'b0, 1'b0, 8'h00);

    // clamp, then load+start together
    step(1'b1, 1'b0, 1'b1, 8'hAF);
    chk("clamp_count", {8'h0, count}, 16'h0099);
    step(1'b1, 1'b1, 1'b1, 8'h20);
    repeat (6) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("load_wins", {8'h0, count}, 16'h0020);

    // expiry then restart from reload
    step(1'b1, 1'b0, 1'b1, 8'h02);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (12) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("exp2_done", {15'h0, done}, 16'h0001);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("restart_count", {8'h0, count}, 16'h0002);
    chk("restart_done", {15'h0, done}, 16'h0000);
    repeat (16) step(1'b1, 1'b0, 1'b0, 8'h00);

    // reset mid-run
    step(1'b1, 1'b0, 1'b1, 8'h42);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("midrun_count", {8'h0, count}, 16'h0042);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("midrun_rst_count", {8'h0, count}, 16'h0003);
    chk("midrun_rst_done", {15'h0, done}, 16'h0000);
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      rr = ($urandom_range(0, 299) != 0);
      rl = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) rv = 8'($urandom);
      else rv = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
      step(rr, rs, rl, rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
